tc_serializer: RTL
==================

# tc_serializer

Parallel-to-serial front end for the serial two's-complement stage. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock. It marks each frame with a one-cycle frame-start strobe, which drives the complementer's clear input, and with a last-bit strobe for downstream collection. The serial data output feeds the complementer's data input directly.

## Interface
- WIDTH, 8, word length in bits; legal range ≥ 2.
- t_clk  input  1  clock, rising-edge active.
- r  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word, sampled on accept.
- in_valid  input  1  din is valid.
- in_ready  output  1  block can accept a word this cycle.
- so  output  1  serial data bit, LSB first.
- sv  output  1  so carries a frame bit this cycle.
- fs  output  1  frame start; high on bit 0 only. Drives the complementer's clear.
- last  output  1  high on bit WIDTH-1 only.

## Operation
- State: shift register sreg[WIDTH-1:0], bit counter cnt (width $clog2(WIDTH)), flag active. States are IDLE (active=0) and SHIFT (active=1).
- Accept: a word is accepted on a rising edge where in_valid & in_ready & !r.
- On accept: sreg<=din, cnt<=0, active<=1.
- SHIFT, per edge:
  - sreg<=sreg>>1 with zero fill.
  - cnt<=cnt+1.
  - If cnt==WIDTH-1, the frame ends. Without a new accept: active<=0 and cnt<=0. With a new accept (macro only): reload as above.
- Outputs are combinational from registers only:
  - sv=active
  - so=active & sreg[0]
  - fs=active & (cnt==0)
  - last=active & (cnt==WIDTH-1)
- Idle outputs: outside a frame, so/fs/last are 0.
- in_ready depends only on state, never on in_valid (no combinational valid→ready path):
  - Base: in_ready=!active.
- din is ignored except on accept. din changing mid-frame has no effect.
- Arithmetic: cnt compares against WIDTH-1 at full width. No wrap past WIDTH-1 is reachable.
- Reset:
  - r high at an edge forces sreg=0, cnt=0, active=0.
  - Reset value of every output: in_ready=1, so=0, sv=0, fs=0, last=0.
  - Reset wins over a simultaneous accept; the word is dropped.
  - Reset mid-frame aborts the frame. No further bits of it are emitted.

## Timing
- Latency: accept at edge k → bit 0 on so (with fs=1, sv=1) during the cycle after edge k.
- Frame length: bit n appears in cycle k+1+n. last is high in cycle k+WIDTH. A frame occupies exactly WIDTH consecutive cycles with sv=1.
- Strobes: fs and last are single-cycle pulses per frame. They coincide only if WIDTH=1, which is illegal.
- Base inter-frame gap: at least one idle cycle (sv=0) between frames. With in_valid held high, the next accept happens on the edge ending the first idle cycle.
- Handshake hold: in_valid may be held across SHIFT. The word stays pending until in_ready=1, and is not lost.

## Configuration
- TC_SER_B2B_EN defined:
  - in_ready = !active | (cnt==WIDTH-1).
  - An accept on the last-bit edge reloads sreg, keeps active=1 and sets cnt=0.
  - Frames are back-to-back with zero gap. fs of frame N+1 immediately follows last of frame N.
- TC_SER_B2B_EN undefined:
  - in_ready = !active.
  - Minimum one idle cycle between frames.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then accept din=8'h06 → so over 8 cycles = 0,1,1,0,0,0,0,0. fs only on cycle 1, last only on cycle 8, sv high for exactly 8 cycles, in_ready=0 throughout.
- in_valid held with 8'hA5 then 8'h3C → macro off: one cycle with sv=0 between frames, second frame so=0,0,1,1,1,1,0,0. Macro on: zero gap, fs of frame 2 in the cycle right after last of frame 1.
- in_valid=1 with din=8'hFF during bits 1..6 of frame 8'h01 (macro off) → in_ready=0, nothing captured, output stays 1,0,0,0,0,0,0,0.
- r=1 at bit 3 of frame 8'hFF → next cycle sv=so=fs=last=0, in_ready=1. r=1 together with in_valid=1 → no frame starts.
- din=8'h80 → so=0 ×7 then 1, last coinciding with the 1. din=8'h00 → sv high for 8 cycles with so=0 throughout.
- WIDTH=2 instance, din=2'b10 → so=0 then 1; fs and last on separate consecutive cycles.

Source files
------------

// File: rtl/tc_serializer.sv
// LSB-first parallel-to-serial front end for the serial two's-complement stage.
// Build option TC_SER_B2B_EN: accept a new word on the last-bit cycle for gapless frames.
module tc_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             sv,
  output logic             fs,
  output logic             last
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] sreg;
  logic [CntW-1:0]  cnt;
  logic             active;
  logic             cnt_last;
  logic             accept;

  assign active   = (state == StShift);
  assign cnt_last = (cnt == LastCnt);

`ifdef TC_SER_B2B_EN
  assign in_ready = !active | cnt_last;
`else
  assign in_ready = !active;
`endif

  // in_ready is a function of state only, so accept never loops back into ready.
  assign accept = in_valid & in_ready;

  always_ff @(posedge t_clk) begin
    if (r) begin
      state <= StIdle;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            state <= StShift;
            sreg  <= din;
            cnt   <= '0;
          end
        end
        StShift: begin
          if (cnt_last) begin
            if (accept) begin
              sreg <= din;
              cnt  <= '0;
            end else begin
              state <= StIdle;
              sreg  <= sreg >> 1;
              cnt   <= '0;
            end
          end else begin
            sreg <= sreg >> 1;
            cnt  <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign sv   = active;
  assign so   = active & sreg[0];
  assign fs   = active & (cnt == '0);
  assign last = active & cnt_last;

endmodule
